// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one asynchronous 512Kx8 SRAM between the I2S playback
// read port and the SPI host read/write port. Fixed-length strobe sequences,
// round-robin arbitration, all pad signals registered.
module sram_arbiter #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 8,
  parameter int RD_CYC = 3,
  parameter int WR_CYC = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p_req,
  input  logic [ADDR_W-1:0] p_addr,
  output logic              p_ack,
  output logic [DATA_W-1:0] p_rdata,
  input  logic              h_req,
  input  logic              h_we,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic [DATA_W-1:0] h_wdata,
  output logic              h_ack,
  output logic [DATA_W-1:0] h_rdata,
  output logic              ram_ce_o,
  output logic              ram_oe_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_a_o,
  output logic [DATA_W-1:0] ram_dq_o,
  output logic              ram_dq_oe,
  input  logic [DATA_W-1:0] ram_dq_i,
  output logic              busy
);

  localparam int MAX_CYC = (RD_CYC > WR_CYC) ? RD_CYC : WR_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_CYC - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR_SETUP,
    S_WR_PULSE,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_grant_host_q, last_grant_host_d;
  logic              gnt_host_q, gnt_host_d;
  logic              is_wr_q, is_wr_d;
  logic [ADDR_W-1:0] ram_a_q, ram_a_d;
  logic [DATA_W-1:0] ram_dq_q, ram_dq_d;
  logic              ram_ce_q, ram_ce_d;
  logic              ram_oe_q, ram_oe_d;
  logic              ram_we_q, ram_we_d;
  logic              ram_dq_oe_q, ram_dq_oe_d;
  logic [DATA_W-1:0] p_rdata_q, p_rdata_d;
  logic [DATA_W-1:0] h_rdata_q, h_rdata_d;
  logic              grant_p;

  // Playback wins when it is alone or when the host was served last.
  assign grant_p = p_req && (!h_req || last_grant_host_q);

  // Next-state, request latching and registered strobe values derived from
  // the state being entered so the pads change on the same edge as the state.
  always_comb begin
    state_d           = state_q;
    cnt_d             = cnt_q;
    last_grant_host_d = last_grant_host_q;
    gnt_host_d        = gnt_host_q;
    is_wr_d           = is_wr_q;
    ram_a_d           = ram_a_q;
    ram_dq_d          = ram_dq_q;
    p_rdata_d         = p_rdata_q;
    h_rdata_d         = h_rdata_q;

    case (state_q)
      S_IDLE: begin
        if (grant_p) begin
          state_d           = S_RD;
          cnt_d             = RD_LOAD;
          gnt_host_d        = 1'b0;
          last_grant_host_d = 1'b0;
          is_wr_d           = 1'b0;
          ram_a_d           = p_addr;
        end else if (h_req) begin
          gnt_host_d        = 1'b1;
          last_grant_host_d = 1'b1;
          is_wr_d           = h_we;
          ram_a_d           = h_addr;
          if (h_we) begin
            state_d  = S_WR_SETUP;
            ram_dq_d = h_wdata;
          end else begin
            state_d = S_RD;
            cnt_d   = RD_LOAD;
          end
        end
      end
      S_RD: begin
        if (cnt_q == '0) begin
          state_d = S_DONE;
          if (gnt_host_q) begin
            h_rdata_d = ram_dq_i;
          end else begin
            p_rdata_d = ram_dq_i;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_WR_SETUP: begin
        state_d = S_WR_PULSE;
        cnt_d   = WR_LOAD;
      end
      S_WR_PULSE: begin
        if (cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    ram_ce_d    = !((state_d == S_RD) || (state_d == S_WR_SETUP) ||
                    (state_d == S_WR_PULSE));
    ram_oe_d    = (state_d != S_RD);
    ram_we_d    = (state_d != S_WR_PULSE);
    ram_dq_oe_d = (state_d == S_WR_SETUP) || (state_d == S_WR_PULSE) ||
                  ((state_d == S_DONE) && is_wr_d);
  end

  // State and pad registers; reset aborts any access and releases strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= S_IDLE;
      cnt_q             <= '0;
      last_grant_host_q <= 1'b1;
      gnt_host_q        <= 1'b0;
      is_wr_q           <= 1'b0;
      ram_a_q           <= '0;
      ram_dq_q          <= '0;
      ram_ce_q          <= 1'b1;
      ram_oe_q          <= 1'b1;
      ram_we_q          <= 1'b1;
      ram_dq_oe_q       <= 1'b0;
      p_rdata_q         <= '0;
      h_rdata_q         <= '0;
    end else begin
      state_q           <= state_d;
      cnt_q             <= cnt_d;
      last_grant_host_q <= last_grant_host_d;
      gnt_host_q        <= gnt_host_d;
      is_wr_q           <= is_wr_d;
      ram_a_q           <= ram_a_d;
      ram_dq_q          <= ram_dq_d;
      ram_ce_q          <= ram_ce_d;
      ram_oe_q          <= ram_oe_d;
      ram_we_q          <= ram_we_d;
      ram_dq_oe_q       <= ram_dq_oe_d;
      p_rdata_q         <= p_rdata_d;
      h_rdata_q         <= h_rdata_d;
    end
  end

  assign p_ack     = (state_q == S_DONE) && !gnt_host_q;
  assign h_ack     = (state_q == S_DONE) && gnt_host_q;
  assign p_rdata   = p_rdata_q;
  assign h_rdata   = h_rdata_q;
  assign ram_ce_o  = ram_ce_q;
  assign ram_oe_o  = ram_oe_q;
  assign ram_we_o  = ram_we_q;
  assign ram_a_o   = ram_a_q;
  assign ram_dq_o  = ram_dq_q;
  assign ram_dq_oe = ram_dq_oe_q;
  assign busy      = (state_q != S_IDLE);

endmodule
